// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_sequencer
// Purpose  : Multi-cycle unsigned shift-add multiplier (low 32 product bits)
//            that drives the shared execute-stage ALU one micro-op per cycle.
// Revision : 1.0  initial release
// ============================================================================
module alu_mul_sequencer #(
    parameter int         WIDTH  = 32,
    parameter logic [3:0] OP_ADD = 4'b0000,
    parameter logic [3:0] OP_SLL = 4'b0111,
    parameter logic [3:0] OP_SRL = 4'b1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH-1:0] alu_d0,
    output logic [WIDTH-1:0] alu_d1,
    output logic [3:0]       alu_s,
    input  logic [WIDTH-1:0] alu_y
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC  = 3'd1,
        ST_SHL  = 3'd2,
        ST_SHR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mult;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_mcand_nxt;
    logic [WIDTH-1:0] w_mult_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mult  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_mcand <= w_mcand_nxt;
            r_mult  <= w_mult_nxt;
        end
    end

    // One ALU micro-op per state; the loop ends as soon as the multiplier
    // has shifted down to zero, so no iteration counter is kept.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_mcand_nxt = r_mcand;
        w_mult_nxt  = r_mult;
        alu_d0      = '0;
        alu_d1      = '0;
        alu_s       = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                if (start_valid) begin
                    w_acc_nxt   = '0;
                    w_mcand_nxt = a_in;
                    w_mult_nxt  = b_in;
                    w_state_nxt = (b_in == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                alu_d0      = r_acc;
                alu_d1      = r_mcand;
                alu_s       = OP_ADD;
                if (r_mult[0]) begin
                    w_acc_nxt = alu_y;
                end
                w_state_nxt = ST_SHL;
            end
            ST_SHL: begin
                alu_d0      = r_mcand;
                alu_d1      = c_one;
                alu_s       = OP_SLL;
                w_mcand_nxt = alu_y;
                w_state_nxt = ST_SHR;
            end
            ST_SHR: begin
                alu_d0      = r_mult;
                alu_d1      = c_one;
                alu_s       = OP_SRL;
                w_mult_nxt  = alu_y;
                w_state_nxt = (alu_y == '0) ? ST_DONE : ST_ACC;
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign start_ready = (r_state == ST_IDLE);
    assign res_valid   = (r_state == ST_DONE);
    assign busy        = (r_state != ST_IDLE);
    assign result      = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_sequencer
// Purpose  : Self-checking bench for alu_mul_sequencer with an attached ALU.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] result;
    logic        busy;
    logic [31:0] alu_d0;
    logic [31:0] alu_d1;
    logic [3:0]  alu_s;
    logic [31:0] alu_y;
    logic [31:0] status;

    int passed = 0;
    int total  = 0;

    alu_mul_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .busy        (busy),
        .alu_d0      (alu_d0),
        .alu_d1      (alu_d1),
        .alu_s       (alu_s),
        .alu_y       (alu_y)
    );

    always #5 clk = ~clk;

    // Shared execute-stage ALU, combinational
    always_comb begin
        case (alu_s)
            4'b0000: alu_y = alu_d0 + alu_d1;
            4'b0111: alu_y = alu_d0 << alu_d1[4:0];
            4'b1000: alu_y = alu_d0 >> alu_d1[4:0];
            default: alu_y = '0;
        endcase
    end

    // {start_ready, res_valid, busy}
    assign status = {29'd0, start_ready, res_valid, busy};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one job and checks every cycle against arithmetic expectations.
    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp_res;
        logic [63:0] part;
        int          k;
        int          lat;
        int          cyc;
        int          i;
        int          ph;
        exp_res = a * b;
        k = -1;
        for (int j = 0; j < 32; j++) if (b[j]) k = j;
        lat = 1 + 3 * (k + 1);

        cyc = 0;
        while (!start_ready && cyc < 10) begin
            step();
            cyc++;
        end
        check("start_ready_before_job", {31'd0, start_ready}, 32'd1);

        start_valid = 1'b1;
        a_in = a;
        b_in = b;
        step();
        a_in = $urandom;
        b_in = $urandom;
        cyc = 1;
        while (!res_valid && cyc <= 100) begin
            start_valid = 1'($urandom_range(0, 1));
            i  = (cyc - 1) / 3;
            ph = (cyc - 1) % 3;
            check("status_busy", status, 32'd1);
            case (ph)
                0: begin
                    part = 64'(a) * (64'(b) & ((64'd1 << i) - 64'd1));
                    check("acc_s", {28'd0, alu_s}, 32'h0);
                    check("acc_d0", alu_d0, part[31:0]);
                    check("acc_d1", alu_d1, a << i);
                end
                1: begin
                    check("shl_s", {28'd0, alu_s}, 32'h7);
                    check("shl_d0", alu_d0, a << i);
                    check("shl_d1", alu_d1, 32'd1);
                end
                default: begin
                    check("shr_s", {28'd0, alu_s}, 32'h8);
                    check("shr_d0", alu_d0, b >> i);
                    check("shr_d1", alu_d1, 32'd1);
                end
            endcase
            step();
            cyc++;
        end
        start_valid = 1'b0;
        check("latency", 32'(cyc), 32'(lat));
        check("result", result, exp_res);
        check("status_done", status, 32'd3);
        check("done_alu_s", {28'd0, alu_s}, 32'h0);

        for (int h = 0; h < hold; h++) begin
            start_valid = 1'b1;
            step();
            check("result_hold", result, exp_res);
            check("status_hold", status, 32'd3);
        end
        res_ready   = 1'b1;
        start_valid = 1'b1;
        step();
        res_ready   = 1'b0;
        start_valid = 1'b0;
        check("idle_after_accept", status, 32'd4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen_valid;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0;
        repeat (2) step();
        check("reset_status", status, 32'd4);
        check("reset_result", result, 32'd0);
        check("reset_alu", alu_d0 | alu_d1 | {28'd0, alu_s}, 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_status", status, 32'd4);

        run_job(32'd7, 32'd6, 0);
        run_job(32'h12345678, 32'd0, 0);
        run_job(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_job(32'd3, 32'd5, 5);

        // Abort a long job with reset
        start_valid = 1'b1;
        a_in = 32'd9;
        b_in = 32'h80000000;
        step();
        start_valid = 1'b0;
        seen_valid = 1'b0;
        repeat (19) begin
            seen_valid |= res_valid;
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_status", status, 32'd4);
        check("abort_result", result, 32'd0);
        repeat (6) begin
            seen_valid |= res_valid;
            step();
        end
        check("abort_no_valid", {31'd0, seen_valid}, 32'd0);
        run_job(32'd2, 32'd3, 0);

        run_job(32'd4, 32'd4, 0);
        run_job(32'h10000, 32'h10000, 0);

        for (int n = 0; n < 20; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_job(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle unsigned shift-add multiplier that borrows the shared combinational ALU instead of instantiating its own adder or shifters.
- Accepts an operand pair on a valid/ready handshake and drives the ALU operand and opcode ports one micro-op per cycle.
- Returns the low 32 bits of the product (RV32M MUL semantics) on a valid/ready result handshake.
- Sits beside the ALU in the execute stage; the mux that gives it ALU ownership is outside this block.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- OP_ADD, 4'b0000, ALU select code for add.
- OP_SLL, 4'b0111, ALU select code for shift-left-logical.
- OP_SRL, 4'b1000, ALU select code for shift-right-logical.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start_valid  in  1  operand pair valid.
- start_ready  out  1  high exactly when state==IDLE.
- a_in  in  32  multiplicand.
- b_in  in  32  multiplier.
- res_valid  out  1  high exactly when state==DONE.
- res_ready  in  1  consumer accepts result.
- result  out  32  product low word; equals the acc register.
- busy  out  1  high in ACC/SHL/SHR/DONE.
- alu_d0  out  32  ALU operand 0.
- alu_d1  out  32  ALU operand 1.
- alu_s  out  4  ALU select.
- alu_y  in  32  ALU result, combinational in the same cycle.

Behaviour:
- Registers: state, acc, mcand, mult (32b each).
- Reset: rst_n low at an edge gives state=IDLE and acc=mcand=mult=0.
  - After reset: start_ready=1, res_valid=0, busy=0, result=0.
  - Reset mid-operation aborts immediately; no res_valid is produced.
- IDLE:
  - ALU ports driven 0 (alu_s=4'b0000).
  - On start_valid: acc<=0, mcand<=a_in, mult<=b_in.
  - Next state is DONE if b_in==0, else ACC.
- ACC:
  - alu_d0=acc, alu_d1=mcand, alu_s=OP_ADD.
  - acc<=alu_y if mult[0]==1, else acc unchanged.
  - Next state SHL.
- SHL:
  - alu_d0=mcand, alu_d1=1, alu_s=OP_SLL.
  - mcand<=alu_y; next state SHR.
- SHR:
  - alu_d0=mult, alu_d1=1, alu_s=OP_SRL.
  - mult<=alu_y; next state DONE if alu_y==0, else ACC.
- DONE:
  - ALU ports driven 0.
  - On res_ready: next state IDLE; otherwise hold with result stable.
- Handshake rules:
  - start_valid is ignored outside IDLE.
  - A start cannot be accepted in the same cycle as result acceptance; there is a minimum one-cycle IDLE between jobs.
- Arithmetic:
  - All wrap modulo 2^32; carries out of bit 31 are discarded.
  - Result = (a_in*b_in) mod 2^32.
- Latency: start accepted at edge T, with k = index of the highest set bit of b_in.
  - res_valid first high in cycle T+1+3(k+1).
  - b_in==0 gives res_valid in cycle T+1.
  - Worst case (k=31): T+97.
- Early termination is the only termination. No iteration counter is needed because mult reaches 0 after at most 32 SHR steps.
- Operands are sampled only at acceptance; later changes on a_in/b_in have no effect.

Test Plan:
- a=7, b=6 (k=2), res_ready=1 -> res_valid in cycle T+10, result=42; alu_s sequence 0000,0111,1000 repeated 3 times.
- a=0x12345678, b=0 -> DONE in cycle T+1, result=0; no ACC/SHL/SHR cycles observed.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> res_valid at T+97, result=0x00000001; start_ready=0 for the whole run.
- a=3, b=5 with res_ready held low 5 cycles after res_valid -> result=15 stable; start_valid pulses ignored; returns to IDLE the cycle after res_ready=1.
- Start a=9, b=0x80000000, then rst_n=0 at T+20 -> next cycle state IDLE, start_ready=1, res_valid never asserted; a following job with a=2, b=3 returns 6.
- Two back-to-back jobs (4×4 then 0x10000×0x10000) -> results 16 then 0x00000000; at least one IDLE cycle between them.
